// File: rtl/packed_divider_if.sv
// Request/response bundle for packed_divider.
//
// Handshake: a transfer happens on a rising clk edge where the sender's valid
// and the receiver's ready are both high. The sender holds its payload stable
// while valid is high. Neither side's valid may wait on the other side's ready.
// PD_STATE_o is the divider's FSM state, exposed for debug and checkers.
interface packed_divider_if;
  logic [31:0] PD_A_i;
  logic [31:0] PD_B_i;
  logic [1:0]  PD_SIZE_i;
  logic        PD_SIGNED_i;
  logic        PD_VALID_i;
  logic        PD_READY_o;
  logic [31:0] PD_Q_o;
  logic [31:0] PD_R_o;
  logic        PD_VALID_o;
  logic        PD_READY_i;
  logic [1:0]  PD_STATE_o;

  modport master (
    output PD_A_i, PD_B_i, PD_SIZE_i, PD_SIGNED_i, PD_VALID_i, PD_READY_i,
    input  PD_READY_o, PD_Q_o, PD_R_o, PD_VALID_o, PD_STATE_o
  );

  modport slave (
    input  PD_A_i, PD_B_i, PD_SIZE_i, PD_SIGNED_i, PD_VALID_i, PD_READY_i,
    output PD_READY_o, PD_Q_o, PD_R_o, PD_VALID_o, PD_STATE_o
  );
endinterface

// File: rtl/packed_divider.sv
// Packed (SIMD) radix-2 restoring divider: 1x32, 2x16 or 4x8 lanes.
// One quotient bit per lane per cycle on a shared partitioned subtractor.
// Optional macro PACKED_DIV_SIGNED_EN enables signed mode; without it
// PD_SIGNED_i is ignored and every lane is unsigned (latency unchanged).
module packed_divider (
  input  logic             clk,
  input  logic             rst_n,
  packed_divider_if.slave  pd
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;

  state_t      state_q;
  logic [31:0] rem_q;    // partial remainders, one per lane
  logic [31:0] qd_q;     // dividend bits shift out the top, quotient bits shift in
  logic [31:0] dv_q;     // divisor magnitudes
  logic [1:0]  size_q;   // normalised lane size (never 2'b11)
  logic [4:0]  cnt_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] q_q;
  logic [31:0] r_q;

  logic [1:0]  in_size;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] rem_d;
  logic [31:0] qd_d;

  // Size 11 is an alias of 1x32
  assign in_size = (pd.PD_SIZE_i == 2'b11) ? 2'b00 : pd.PD_SIZE_i;

`ifdef PACKED_DIV_SIGNED_EN
  logic [3:0] qneg_q;    // per byte: negate the quotient lane
  logic [3:0] rneg_q;    // per byte: negate the remainder lane
  logic [3:0] in_qneg;
  logic [3:0] in_rneg;
  logic [3:0] in_zero;
  logic [3:0] sa;
  logic [3:0] sb;

  function automatic logic [31:0] expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Two's-complement negate of each lane, carries stop at lane boundaries
  function automatic logic [31:0] neg_lanes(input logic [31:0] x, input logic [1:0] sz);
    logic [31:0] y;
    case (sz)
      2'b10:   y = {~x[31:24] + 8'd1, ~x[23:16] + 8'd1, ~x[15:8] + 8'd1, ~x[7:0] + 8'd1};
      2'b01:   y = {~x[31:16] + 16'd1, ~x[15:0] + 16'd1};
      default: y = ~x + 32'd1;
    endcase
    return y;
  endfunction

  // Sign bit of the lane each byte belongs to
  function automatic logic [3:0] lane_sign(input logic [31:0] x, input logic [1:0] sz);
    logic [3:0] s;
    case (sz)
      2'b10:   s = {x[31], x[23], x[15], x[7]};
      2'b01:   s = {x[31], x[31], x[15], x[15]};
      default: s = {4{x[31]}};
    endcase
    return s;
  endfunction

  // Lane-is-zero flag of the lane each byte belongs to
  function automatic logic [3:0] lane_zero(input logic [31:0] x, input logic [1:0] sz);
    logic [3:0] z;
    case (sz)
      2'b10:   z = {x[31:24] == 8'd0, x[23:16] == 8'd0, x[15:8] == 8'd0, x[7:0] == 8'd0};
      2'b01:   z = {{2{x[31:16] == 16'd0}}, {2{x[15:0] == 16'd0}}};
      default: z = {4{x == 32'd0}};
    endcase
    return z;
  endfunction

  // Sign-magnitude conversion of the incoming operands. Divide-by-zero lanes
  // keep the raw dividend and get no fixups, so they come out as Q=ones, R=A.
  always_comb begin
    in_zero = lane_zero(pd.PD_B_i, in_size);
    sa      = pd.PD_SIGNED_i ? lane_sign(pd.PD_A_i, in_size) : 4'b0000;
    sb      = pd.PD_SIGNED_i ? lane_sign(pd.PD_B_i, in_size) : 4'b0000;
    in_a    = (expand(sa & ~in_zero) & neg_lanes(pd.PD_A_i, in_size)) |
              (~expand(sa & ~in_zero) & pd.PD_A_i);
    in_b    = (expand(sb) & neg_lanes(pd.PD_B_i, in_size)) | (~expand(sb) & pd.PD_B_i);
    in_qneg = (sa ^ sb) & ~in_zero;
    in_rneg = sa & ~in_zero;
  end
`else
  logic unused_signed;
  assign unused_signed = pd.PD_SIGNED_i;
  assign in_a = pd.PD_A_i;
  assign in_b = pd.PD_B_i;
`endif

  // One restoring step in every lane: shift, partitioned trial subtract, select
  always_comb begin
    logic [31:0] sh;
    logic [31:0] diff;
    logic [3:0]  top;
    logic [3:0]  bo;
    logic [3:0]  ge;
    logic [8:0]  sub9;
    logic        brw;
    sh   = '0;
    diff = '0;
    top  = '0;
    bo   = '0;
    ge   = '0;
    sub9 = '0;
    brw  = 1'b0;
    rem_d = '0;
    qd_d  = '0;
    case (size_q)
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          sh[8*i +: 8] = {rem_q[8*i +: 7], qd_q[8*i+7]};
          top[i]       = rem_q[8*i+7];
        end
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          sh[16*k +: 16] = {rem_q[16*k +: 15], qd_q[16*k+15]};
          top[2*k]       = rem_q[16*k+15];
          top[2*k+1]     = rem_q[16*k+15];
        end
      end
      default: begin
        sh  = {rem_q[30:0], qd_q[31]};
        top = {4{rem_q[31]}};
      end
    endcase
    // byte-sliced subtractor; the borrow is cleared at every lane start
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || size_q == 2'b10 || (size_q == 2'b01 && i == 2)) brw = 1'b0;
      sub9 = {1'b0, sh[8*i +: 8]} - {1'b0, dv_q[8*i +: 8]} - {8'd0, brw};
      diff[8*i +: 8] = sub9[7:0];
      brw   = sub9[8];
      bo[i] = brw;
    end
    // the shifted-out top bit means the trial value already exceeds the divisor
    case (size_q)
      2'b10:   ge = top | ~bo;
      2'b01:   ge = {{2{top[3] | ~bo[3]}}, {2{top[1] | ~bo[1]}}};
      default: ge = {4{top[3] | ~bo[3]}};
    endcase
    for (int i = 0; i < 4; i++) begin
      rem_d[8*i +: 8] = ge[i] ? diff[8*i +: 8] : sh[8*i +: 8];
    end
    case (size_q)
      2'b10: begin
        for (int i = 0; i < 4; i++) qd_d[8*i +: 8] = {qd_q[8*i +: 7], ge[i]};
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) qd_d[16*k +: 16] = {qd_q[16*k +: 15], ge[2*k]};
      end
      default: qd_d = {qd_q[30:0], ge[0]};
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      qd_q    <= '0;
      dv_q    <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef PACKED_DIV_SIGNED_EN
      qneg_q  <= '0;
      rneg_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pd.PD_VALID_i && ready_q) begin
            rem_q   <= '0;
            qd_q    <= in_a;
            dv_q    <= in_b;
            size_q  <= in_size;
            cnt_q   <= (in_size == 2'b10) ? 5'd7 : (in_size == 2'b01) ? 5'd15 : 5'd31;
            ready_q <= 1'b0;
            state_q <= S_CALC;
`ifdef PACKED_DIV_SIGNED_EN
            qneg_q  <= in_qneg;
            rneg_q  <= in_rneg;
`endif
          end else begin
            // raised one cycle after a result handshake
            ready_q <= 1'b1;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          qd_q  <= qd_d;
          if (cnt_q == 5'd0) state_q <= S_FIX;
          else               cnt_q   <= cnt_q - 5'd1;
        end
        S_FIX: begin
`ifdef PACKED_DIV_SIGNED_EN
          q_q <= (expand(qneg_q) & neg_lanes(qd_q, size_q)) | (~expand(qneg_q) & qd_q);
          r_q <= (expand(rneg_q) & neg_lanes(rem_q, size_q)) | (~expand(rneg_q) & rem_q);
`else
          q_q <= qd_q;
          r_q <= rem_q;
`endif
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (pd.PD_READY_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pd.PD_READY_o = ready_q;
  assign pd.PD_VALID_o = valid_q;
  assign pd.PD_Q_o     = q_q;
  assign pd.PD_R_o     = r_q;
  assign pd.PD_STATE_o = state_q;

endmodule

// File: tb/tb_packed_divider.sv
// Self-checking bench for packed_divider: directed vectors, backpressure,
// mid-operation reset and random packed divides against a lane-level model.
module tb_packed_divider;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  packed_divider_if pd_if ();

  packed_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pd    (pd_if.slave)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int lane_bits(input logic [1:0] sz);
    return (sz == 2'b01) ? 16 : (sz == 2'b10) ? 8 : 32;
  endfunction

  // Lane-wise reference: {Q, R}
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] sz, input logic sgn);
    int     n;
    longint mask, half, ua, ub, sa, sb, qq, rr, qacc, racc;
    logic   s;
    n = lane_bits(sz);
`ifdef PACKED_DIV_SIGNED_EN
    s = sgn;
`else
    s = sgn & 1'b0;
`endif
    mask = (64'sd1 <<< n) - 1;
    half = 64'sd1 <<< (n - 1);
    qacc = 0;
    racc = 0;
    for (int l = 0; l < 32 / n; l++) begin
      ua = (longint'(a) >> (l * n)) & mask;
      ub = (longint'(b) >> (l * n)) & mask;
      if (ub == 0) begin
        qq = mask;
        rr = ua;
      end else if (!s) begin
        qq = ua / ub;
        rr = ua % ub;
      end else begin
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        if (sa == -half && sb == -1) begin
          qq = sa;
          rr = 0;
        end else begin
          qq = sa / sb;
          rr = sa % sb;
        end
      end
      qacc = qacc | ((qq & mask) << (l * n));
      racc = racc | ((rr & mask) << (l * n));
    end
    return {qacc[31:0], racc[31:0]};
  endfunction

  // Drive one request and push its expectation at the accepting edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] sz, input logic sg);
    int w;
    @(negedge clk);
    pd_if.PD_A_i      = a;
    pd_if.PD_B_i      = b;
    pd_if.PD_SIZE_i   = sz;
    pd_if.PD_SIGNED_i = sg;
    pd_if.PD_VALID_i  = 1'b1;
    w = 0;
    while (!pd_if.PD_READY_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 64'(pd_if.PD_READY_o), 64'd1);
    @(posedge clk);
    exp_q.push_back(model(a, b, sz, sg));
    lat_q.push_back(lane_bits(sz) + 1);
    @(negedge clk);
    pd_if.PD_VALID_i = 1'b0;
  endtask

  // Wait for the result, score it, apply `hold` cycles of backpressure, then accept
  task automatic finish_op(input int hold);
    int          lat;
    int          el;
    logic [63:0] e;
    logic [31:0] q0, r0;
    lat = 0;
    while (!pd_if.PD_VALID_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("result_valid", 64'(pd_if.PD_VALID_o), 64'd1);
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      check("latency", 64'(lat), 64'(el));
      check("quotient", 64'(pd_if.PD_Q_o), 64'(e[63:32]));
      check("remainder", 64'(pd_if.PD_R_o), 64'(e[31:0]));
    end
    q0 = pd_if.PD_Q_o;
    r0 = pd_if.PD_R_o;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        pd_if.PD_A_i     = $urandom;
        pd_if.PD_B_i     = $urandom;
        pd_if.PD_SIZE_i  = 2'($urandom_range(0, 3));
        pd_if.PD_VALID_i = 1'b1;
      end
      if (i == 2) pd_if.PD_VALID_i = 1'b0;
      @(negedge clk);
      check("hold_valid", 64'(pd_if.PD_VALID_o), 64'd1);
      check("hold_qr", {pd_if.PD_Q_o, pd_if.PD_R_o}, {q0, r0});
      check("hold_ready", 64'(pd_if.PD_READY_o), 64'd0);
    end
    pd_if.PD_VALID_i = 1'b0;
    pd_if.PD_READY_i = 1'b1;
    @(negedge clk);
    pd_if.PD_READY_i = 1'b0;
    check("valid_drop", 64'(pd_if.PD_VALID_o), 64'd0);
    check("ready_lag", 64'(pd_if.PD_READY_o), 64'd0);
    @(negedge clk);
    check("ready_back", 64'(pd_if.PD_READY_o), 64'd1);
    check("keep_qr", {pd_if.PD_Q_o, pd_if.PD_R_o}, {q0, r0});
  endtask

  // stimulus
  initial begin
    int          seen;
    logic [31:0] ra, rb;
    logic [1:0]  rs;
    rst_n             = 1'b0;
    pd_if.PD_A_i      = '0;
    pd_if.PD_B_i      = '0;
    pd_if.PD_SIZE_i   = '0;
    pd_if.PD_SIGNED_i = 1'b0;
    pd_if.PD_VALID_i  = 1'b0;
    pd_if.PD_READY_i  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(pd_if.PD_READY_o), 64'd1);
    check("rst_valid", 64'(pd_if.PD_VALID_o), 64'd0);
    check("rst_qr", {pd_if.PD_Q_o, pd_if.PD_R_o}, 64'd0);
    check("rst_state", 64'(pd_if.PD_STATE_o), 64'd0);
    rst_n = 1'b1;

    // 32-bit unsigned
    start_op(32'd100, 32'd7, 2'b00, 1'b0);
    finish_op(0);
    check("tp_u32", {pd_if.PD_Q_o, pd_if.PD_R_o}, {32'd14, 32'd2});

    // 4x8 unsigned with a /0 lane and borrow-sensitive neighbours
    start_op(32'h64FF1009, 32'h0A100300, 2'b10, 1'b0);
    finish_op(0);
    check("tp_u8", {pd_if.PD_Q_o, pd_if.PD_R_o}, {32'h0A0F05FF, 32'h000F0109});

    // 2x16 signed
    start_op(32'hFFF90007, 32'h0002FFFE, 2'b01, 1'b1);
    finish_op(0);
`ifdef PACKED_DIV_SIGNED_EN
    check("tp_s16", {pd_if.PD_Q_o, pd_if.PD_R_o}, {32'hFFFDFFFD, 32'hFFFF0001});
`endif

    // 32-bit signed overflow
    start_op(32'h80000000, 32'hFFFFFFFF, 2'b00, 1'b1);
    finish_op(0);
`ifdef PACKED_DIV_SIGNED_EN
    check("tp_ovf", {pd_if.PD_Q_o, pd_if.PD_R_o}, {32'h80000000, 32'h0});
`endif

    // signed /0 (same result unsigned)
    start_op(32'hFFFFFFF9, 32'h0, 2'b00, 1'b1);
    finish_op(0);
    check("tp_div0", {pd_if.PD_Q_o, pd_if.PD_R_o}, {32'hFFFFFFFF, 32'hFFFFFFF9});

    // size 11 behaves as 1x32
    start_op(32'd100, 32'd7, 2'b11, 1'b0);
    finish_op(0);
    check("tp_size11", {pd_if.PD_Q_o, pd_if.PD_R_o}, {32'd14, 32'd2});

    // backpressure with an ignored request while busy
    start_op(32'hDEADBEEF, 32'h00001234, 2'b01, 1'b0);
    finish_op(5);
    start_op(32'd1000, 32'd33, 2'b00, 1'b0);
    finish_op(0);

    // reset in the middle of a 32-bit divide
    start_op(32'd1000000, 32'd3, 2'b00, 1'b0);
    exp_q.delete();
    lat_q.delete();
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(pd_if.PD_VALID_o), 64'd0);
    check("mid_rst_ready", 64'(pd_if.PD_READY_o), 64'd1);
    check("mid_rst_qr", {pd_if.PD_Q_o, pd_if.PD_R_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (pd_if.PD_VALID_o) seen++;
    end
    check("no_partial_result", 64'(seen), 64'd0);
    start_op(32'd99, 32'd10, 2'b00, 1'b0);
    finish_op(0);
    check("post_rst", {pd_if.PD_Q_o, pd_if.PD_R_o}, {32'd9, 32'd9});

    // random packed divides
    for (int t = 0; t < 16; t++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0F0F0F0F;
      rs = 2'($urandom_range(0, 3));
      start_op(ra, rb, rs, 1'($urandom_range(0, 1)));
      finish_op($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packed_divider.md
Name: packed_divider

Overview:
- Multi-cycle partitioned (SIMD) integer divider for the core's packed-arithmetic datapath; companion to the packed add/sub unit.
- Divides one 32-bit word, two 16-bit lanes or four 8-bit lanes in parallel, using the same lane-size encoding as the packed adder.
- Radix-2 restoring algorithm: one quotient bit per lane per cycle on a shared 32-bit partitioned subtractor, with carry killed at lane boundaries.
- Valid/ready handshake on both sides.

Parameters:
- None. Datapath fixed at 32 bits, lane granularity 8 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- PD_A_i  input  32  dividend (packed lanes)
- PD_B_i  input  32  divisor (packed lanes)
- PD_SIZE_i  input  2  00: 1x32, 01: 2x16, 10: 4x8, 11: 1x32
- PD_SIGNED_i  input  1  0 unsigned, 1 two's-complement signed
- PD_VALID_i  input  1  request valid
- PD_READY_o  output  1  unit can accept a request
- PD_Q_o  output  32  packed quotients
- PD_R_o  output  32  packed remainders
- PD_VALID_o  output  1  result valid
- PD_READY_i  input  1  consumer accepts result

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - On reset: state IDLE, PD_READY_o=1, PD_VALID_o=0, PD_Q_o=0, PD_R_o=0, all internal registers 0.
  - Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- States and transitions:
  - IDLE: PD_READY_o=1. On PD_VALID_i & PD_READY_o at a rising edge, latch A, B, SIZE and SIGNED, then go to CALC.
    - The latched SIZE fixes the lane width N: 32, 16 or 8.
    - Signed mode: store each lane's absolute values plus per-lane sign flags (quotient sign = sign(A) xor sign(B); remainder sign = sign(A)).
  - CALC: PD_READY_o=0. Counter runs N cycles. Each cycle, in every lane:
    - shift the partial remainder left by 1, taking in the dividend MSB;
    - trial-subtract the divisor;
    - if no borrow, keep the difference and set quotient bit 1; else restore and set quotient bit 0.
    - No carry or borrow crosses a lane boundary.
  - FIX (1 cycle): apply signed fixups, register PD_Q_o and PD_R_o, set PD_VALID_o=1, go to DONE.
  - DONE: hold outputs stable with PD_VALID_o=1 until PD_READY_i=1 at a rising edge. Then drop PD_VALID_o and return to IDLE.
    - PD_READY_o rises the following cycle; there is no same-cycle turnaround.
- Latency: PD_VALID_o is high N+1 cycles after the accepting edge (33, 17 or 9 cycles).
- Requests while busy: PD_VALID_i while PD_READY_o=0 is ignored, not queued.
- PD_Q_o and PD_R_o change only on entering DONE. They keep the last result after handshake until the next result is delivered.
- Divide by zero, per lane: Q = all ones in lane, R = dividend lane, in both signed and unsigned modes. Fixups are suppressed for such lanes.
- Signed overflow, per lane (most-negative / -1): Q = most-negative, R = 0.
- Signed rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
- SIZE 11 behaves exactly as SIZE 00.

Optional Feature:
- Macro PACKED_DIV_SIGNED_EN.
- Defined: PD_SIGNED_i honoured as described above, including the sign-magnitude conversion and fixup logic.
- Undefined: PD_SIGNED_i ignored and all lanes treated as unsigned. The FIX cycle remains, so latency is unchanged.

Test Plan:
- 32-bit unsigned: SIZE=00, A=100, B=7 -> Q=14, R=2, PD_VALID_o high 33 cycles after the accepting edge.
- 8-bit lanes, unsigned: A=0x64FF1009, B=0x0A100300 -> Q=0x0A0F05FF, R=0x000F0109 after 9 cycles. Covers the /0 lane and no cross-lane borrow.
- 16-bit signed: A=0xFFF90007, B=0x0002FFFE -> Q=0xFFFDFFFD, R=0xFFFF0001 after 17 cycles.
- 32-bit signed overflow: A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0. Signed /0 with A=0xFFFFFFF9, B=0 -> Q=0xFFFFFFFF, R=0xFFFFFFF9.
- Backpressure: hold PD_READY_i=0 for 5 cycles after PD_VALID_o rises, and pulse PD_VALID_i with new operands meanwhile -> outputs stable, PD_READY_o=0, request ignored. After PD_READY_i=1: PD_VALID_o falls next cycle and PD_READY_o rises the cycle after.
- Reset mid-CALC: assert rst_n=0 at cycle 10 of a 32-bit divide -> PD_VALID_o=0, Q=R=0 and PD_READY_o=1 asynchronously. A new divide after release completes normally.
